// File: rtl/adder_tree_seq.sv
// adder_tree_seq
// Bit-serial sequencer for the banked adder tree. For each job it issues one
// bit-plane index per cycle, tracks each issue through a TREE_LAT-deep delay
// line so the returning tree sum is matched to its plane, and shift-accumulates
// the sums (LSB plane first) into a two's-complement result.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        job request, only honoured in IDLE
//   cfg_nbits    plane count (0 or > MAX_BITS means MAX_BITS), latched on start
//   cfg_signed   last plane carries negative weight, latched on start
//   abort        synchronous cancel from any state
//   tree_sum     unsigned adder tree output, valid TREE_LAT cycles after issue
//   issue_vld    plane read enable to the banks
//   issue_idx    plane index to the banks
//   busy         high whenever a job is in flight (state != IDLE)
//   result_vld   one-cycle pulse when result holds a fresh job sum
//   result       accumulated signed result, held between jobs
module adder_tree_seq #(
  parameter int SUM_W    = 12,
  parameter int MAX_BITS = 8,
  parameter int IDX_W    = 3,
  parameter int TREE_LAT = 2,
  parameter int ACC_W    = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IDX_W:0]   cfg_nbits,
  input  logic             cfg_signed,
  input  logic             abort,
  input  logic [SUM_W-1:0] tree_sum,
  output logic             issue_vld,
  output logic [IDX_W-1:0] issue_idx,
  output logic             busy,
  output logic             result_vld,
  output logic [ACC_W-1:0] result
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t state_q, state_d;

  logic [IDX_W:0]   nbits_q;
  logic             signed_q;
  logic [IDX_W-1:0] idx_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] result_q;

  // Delay line entries: stage TREE_LAT-1 is the entry whose sum is on
  // tree_sum this cycle.
  logic [TREE_LAT-1:0] dl_vld;
  logic [TREE_LAT-1:0] dl_last;
  logic [IDX_W-1:0]    dl_idx [TREE_LAT];

  logic             accept;
  logic             issue_last;
  logic [IDX_W:0]   nbits_clamped;
  logic             emit_vld;
  logic             emit_last;
  logic [ACC_W-1:0] term;
  logic [ACC_W-1:0] acc_next;

  assign accept     = (state_q == IDLE) && start && !abort;
  assign issue_last = (state_q == ISSUE) && ({1'b0, idx_q} == (nbits_q - 1'b1));

  assign nbits_clamped = ((cfg_nbits == '0) || (cfg_nbits > (IDX_W+1)'(MAX_BITS)))
                         ? (IDX_W+1)'(MAX_BITS) : cfg_nbits;

  assign emit_vld  = dl_vld[TREE_LAT-1];
  assign emit_last = dl_last[TREE_LAT-1];

  // The tree sum is a magnitude: zero-extend, then weight by its plane. In
  // signed mode the top plane is the sign plane and is subtracted.
  assign term     = ACC_W'(tree_sum) << dl_idx[TREE_LAT-1];
  assign acc_next = (signed_q && emit_last) ? (acc_q - term) : (acc_q + term);

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)                 state_d = ISSUE;
      ISSUE:   if (issue_last)            state_d = DRAIN;
      DRAIN:   if (emit_vld && emit_last) state_d = DONE;
      DONE:                               state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Job registers, delay line and accumulator. Abort flushes in-flight planes
  // and blocks any accumulation so result keeps its previous value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nbits_q  <= '0;
      signed_q <= 1'b0;
      idx_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      dl_vld   <= '0;
      dl_last  <= '0;
      for (int i = 0; i < TREE_LAT; i++) dl_idx[i] <= '0;
    end else if (abort) begin
      idx_q   <= '0;
      dl_vld  <= '0;
      dl_last <= '0;
    end else begin
      dl_vld[0]  <= (state_q == ISSUE);
      dl_last[0] <= issue_last;
      dl_idx[0]  <= idx_q;
      for (int i = 1; i < TREE_LAT; i++) begin
        dl_vld[i]  <= dl_vld[i-1];
        dl_last[i] <= dl_last[i-1];
        dl_idx[i]  <= dl_idx[i-1];
      end

      if (emit_vld) begin
        acc_q <= acc_next;
        if (emit_last) result_q <= acc_next;
      end

      if (accept) begin
        nbits_q  <= nbits_clamped;
        signed_q <= cfg_signed;
        acc_q    <= '0;
        idx_q    <= '0;
      end else if (state_q == ISSUE) begin
        idx_q <= issue_last ? '0 : idx_q + 1'b1;
      end
    end
  end

  assign issue_vld  = (state_q == ISSUE);
  assign issue_idx  = idx_q;
  assign busy       = (state_q != IDLE);
  assign result_vld = (state_q == DONE);
  assign result     = result_q;

endmodule

// File: tb/tb_adder_tree_seq.sv
// tb_adder_tree_seq
// Self-checking bench for adder_tree_seq. Cycle t of a job is the cycle after
// the t-th clock edge following the accepted start. The bench plays the bank
// array: plane k's sum is presented in cycle k+3 (issue in k+1 plus TREE_LAT),
// and random noise at every other time. Expected results are the plain
// weighted sum of the per-plane values.
module tb_adder_tree_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  cfg_nbits;
  logic        cfg_signed;
  logic        abort;
  logic [11:0] tree_sum;
  logic        issue_vld;
  logic [2:0]  issue_idx;
  logic        busy;
  logic        result_vld;
  logic [19:0] result;

  int          tests;
  int          fails;
  logic [19:0] exp_result;
  logic [11:0] vals [8];

  adder_tree_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_nbits  (cfg_nbits),
    .cfg_signed (cfg_signed),
    .abort      (abort),
    .tree_sum   (tree_sum),
    .issue_vld  (issue_vld),
    .issue_idx  (issue_idx),
    .busy       (busy),
    .result_vld (result_vld),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: sum of vals[k] * 2^k, sign plane negative in signed mode.
  function automatic logic [19:0] model(input int n, input bit sgn);
    longint acc;
    longint term;
    acc = 0;
    for (int k = 0; k < n; k++) begin
      term = longint'(vals[k]) * (longint'(1) << k);
      if (sgn && k == n - 1) acc = acc - term;
      else                   acc = acc + term;
    end
    return acc[19:0];
  endfunction

  function automatic int eff_bits(input logic [3:0] nb);
    return (nb == 0 || nb > 8) ? 8 : int'(nb);
  endfunction

  // Starts a job in the current cycle and checks it cycle by cycle through
  // cycle n+4. abort_at / p1 / p2 are job-relative cycles (-1 = unused).
  task automatic run_job(input logic [3:0] nb, input bit sgn, input int abort_at,
                         input int p1, input int p2);
    int         n;
    bit         aborted;
    bit         ev, eb, er;
    logic [2:0] ei;
    n = eff_bits(nb);
    cfg_nbits  = nb;
    cfg_signed = sgn;
    start      = 1'b1;
    abort      = 1'b0;
    tree_sum   = 12'($urandom);
    for (int t = 1; t <= n + 4; t++) begin
      @(posedge clk); #1;
      start = (t == p1) || (t == p2);
      if (start) begin
        cfg_nbits  = 4'd1;
        cfg_signed = ~sgn;
      end
      abort    = (t == abort_at);
      tree_sum = (t >= 3 && t <= n + 2) ? vals[t-3] : 12'($urandom);
      aborted  = (abort_at > 0) && (t > abort_at);
      ev = !aborted && (t <= n);
      eb = !aborted && (t <= n + 3);
      er = !aborted && (t == n + 3);
      ei = 3'(t - 1);
      tests++;
      if (issue_vld !== ev) begin
        fails++;
        $display("[TB] FAIL issue_vld cycle %0d: got %b want %b", t, issue_vld, ev);
      end
      if (ev) begin
        tests++;
        if (issue_idx !== ei) begin
          fails++;
          $display("[TB] FAIL issue_idx cycle %0d: got %0d want %0d", t, issue_idx, ei);
        end
      end
      tests++;
      if (busy !== eb) begin
        fails++;
        $display("[TB] FAIL busy cycle %0d: got %b want %b", t, busy, eb);
      end
      tests++;
      if (result_vld !== er) begin
        fails++;
        $display("[TB] FAIL result_vld cycle %0d: got %b want %b", t, result_vld, er);
      end
      if (er) exp_result = model(n, sgn);
      if (er || t == n + 4) begin
        tests++;
        if (result !== exp_result) begin
          fails++;
          $display("[TB] FAIL result cycle %0d: got %h want %h", t, result, exp_result);
        end
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic randomize_vals();
    for (int k = 0; k < 8; k++) vals[k] = 12'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_nbits = '0; cfg_signed = 1'b0; tree_sum = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({issue_vld, issue_idx, busy, result_vld, result} !== 25'd0) begin
      fails++;
      $display("[TB] FAIL reset_state: got vld=%b idx=%0d busy=%b rvld=%b res=%h want all 0",
               issue_vld, issue_idx, busy, result_vld, result);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL post_reset_idle: busy got %b want 0", busy);
    end
    exp_result = '0;
  endtask

  task automatic test_unsigned_basic();
    for (int k = 0; k < 8; k++) vals[k] = 12'(k + 1);
    run_job(4'd4, 1'b0, -1, -1, -1);
  endtask

  task automatic test_signed_basic();
    for (int k = 0; k < 8; k++) vals[k] = 12'(k + 1);
    run_job(4'd4, 1'b1, -1, -1, -1);
  endtask

  task automatic test_clamp();
    for (int k = 0; k < 8; k++) vals[k] = 12'hFFF;
    run_job(4'd0, 1'b0, -1, -1, -1);
    randomize_vals();
    run_job(4'd13, 1'b1, -1, -1, -1);
  endtask

  task automatic test_start_ignored();
    randomize_vals();
    run_job(4'd4, 1'b0, -1, 2, 7);
    randomize_vals();
    run_job(4'd3, 1'b1, -1, -1, -1);
  endtask

  task automatic test_abort();
    randomize_vals();
    run_job(4'd5, 1'b0, -1, -1, -1);
    randomize_vals();
    run_job(4'd8, 1'b0, 2, -1, -1);
    randomize_vals();
    run_job(4'd8, 1'b1, -1, -1, -1);
  endtask

  task automatic test_abort_start();
    cfg_nbits = 4'd4; cfg_signed = 1'b0;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    tests++;
    if ({busy, issue_vld} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL abort_wins_start: got busy=%b vld=%b want 0 0", busy, issue_vld);
    end
    @(posedge clk); #1;
    tests++;
    if (result !== exp_result) begin
      fails++;
      $display("[TB] FAIL abort_start_result: got %h want %h", result, exp_result);
    end
  endtask

  task automatic test_reset_mid();
    randomize_vals();
    cfg_nbits = 4'd8; cfg_signed = 1'b0; start = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      tree_sum = (t >= 3) ? vals[t-3] : 12'($urandom);
    end
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL drain_busy: got %b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({issue_vld, issue_idx, busy, result_vld, result} !== 25'd0) begin
      fails++;
      $display("[TB] FAIL async_reset: got vld=%b idx=%0d busy=%b rvld=%b res=%h want all 0",
               issue_vld, issue_idx, busy, result_vld, result);
    end
    exp_result = '0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    vals[0] = 12'd5;
    run_job(4'd1, 1'b1, -1, -1, -1);
  endtask

  task automatic test_random();
    int         n;
    int         ab;
    logic [3:0] nb;
    bit         sgn;
    for (int j = 0; j < 25; j++) begin
      randomize_vals();
      nb  = 4'($urandom_range(0, 15));
      sgn = 1'($urandom);
      n   = eff_bits(nb);
      ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, n + 3)) : -1;
      run_job(nb, sgn, ab, -1, -1);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    exp_result = '0;
    test_reset();
    test_unsigned_basic();
    test_signed_basic();
    test_clamp();
    test_start_ignored();
    test_abort();
    test_abort_start();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
